// File: rtl/vga_arb_pkg.sv
// Shared types and defaults for the screen-memory arbiter.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CPU_ACC    = 2'd1,
    REN_ACC    = 2'd2,
    REN_LOCKED = 2'd3
  } arb_state_e;

  localparam logic ARB_CPU = 1'b0;
  localparam logic ARB_REN = 1'b1;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_MAX_WAIT = 8;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of cycles the CPU has lost arbitration; raises a force
// flag once the count reaches MAX_WAIT. Used only with ARB_STARVE_GUARD_EN.
module arb_starve_cnt
  import vga_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic cpu_win,
  output logic force_c
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  // Cleared by a CPU grant or by the CPU withdrawing; otherwise counts losses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!cpu_req || cpu_win) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign force_c = (wait_cnt >= WAIT_LIMIT);

endmodule

// File: rtl/screen_mem_arbiter.sv
// Single-port screen memory arbiter between CPU (req 0) and glyph renderer (req 1).
// Optional CPU starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module screen_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              CLK50MHz,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_GNT,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_RVALID,
  input  logic              REN_REQ,
  input  logic              REN_WE,
  input  logic [ADDR_W-1:0] REN_ADDR,
  input  logic [DATA_W-1:0] REN_WDATA,
  input  logic              REN_LOCK,
  input  logic              LINE_ACTIVE,
  output logic              REN_GNT,
  output logic [DATA_W-1:0] REN_RDATA,
  output logic              REN_RVALID,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  arb_state_e state;
  arb_state_e state_next;
  logic       rr_next;      // requester favoured on the next LINE_ACTIVE=0 tie
  logic       rd_pend;
  logic       rd_owner;
  logic       cpu_win;
  logic       ren_win;
  logic       lock_hold;
  logic       cpu_force_c;

`ifdef ARB_STARVE_GUARD_EN
  logic starve_force_c;

  arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_cnt (
    .clk    (CLK50MHz),
    .rst    (RST),
    .cpu_req(CPU_REQ),
    .cpu_win(cpu_win),
    .force_c(starve_force_c)
  );

  assign cpu_force_c = starve_force_c & CPU_REQ;
`else
  assign cpu_force_c = 1'b0;
`endif

  // Winner selection and next arbitration mode.
  always_comb begin
    cpu_win    = 1'b0;
    ren_win    = 1'b0;
    state_next = IDLE;
    lock_hold  = REN_LOCK && REN_REQ && (state == REN_ACC || state == REN_LOCKED);

    if (cpu_force_c) begin
      cpu_win = 1'b1;
    end else if (lock_hold) begin
      ren_win = 1'b1;
    end else if (CPU_REQ && REN_REQ) begin
      if (LINE_ACTIVE || rr_next == ARB_REN) ren_win = 1'b1;
      else                                   cpu_win = 1'b1;
    end else if (CPU_REQ) begin
      cpu_win = 1'b1;
    end else if (REN_REQ) begin
      ren_win = 1'b1;
    end

    // A forced CPU slot inside a burst keeps the lock for the following beat.
    if (cpu_win)      state_next = lock_hold ? REN_LOCKED : CPU_ACC;
    else if (ren_win) state_next = lock_hold ? REN_LOCKED : REN_ACC;
  end

  always_ff @(posedge CLK50MHz or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      rr_next    <= ARB_CPU;
      rd_pend    <= 1'b0;
      rd_owner   <= ARB_CPU;
      CPU_GNT    <= 1'b0;
      REN_GNT    <= 1'b0;
      CPU_RVALID <= 1'b0;
      REN_RVALID <= 1'b0;
      CPU_RDATA  <= '0;
      REN_RDATA  <= '0;
      MEM_EN     <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
    end else begin
      state      <= state_next;
      CPU_GNT    <= cpu_win;
      REN_GNT    <= ren_win;
      MEM_EN     <= cpu_win | ren_win;
      CPU_RVALID <= 1'b0;
      REN_RVALID <= 1'b0;

      if (cpu_win) begin
        MEM_WE    <= CPU_WE;
        MEM_ADDR  <= CPU_ADDR;
        MEM_WDATA <= CPU_WDATA;
        rr_next   <= ARB_REN;
      end else if (ren_win) begin
        MEM_WE    <= REN_WE;
        MEM_ADDR  <= REN_ADDR;
        MEM_WDATA <= REN_WDATA;
        rr_next   <= ARB_CPU;
      end else begin
        MEM_WE <= 1'b0;
      end

      // Tag each read with its issuer; return the data one cycle later.
      rd_pend  <= (cpu_win & ~CPU_WE) | (ren_win & ~REN_WE);
      rd_owner <= ren_win ? ARB_REN : ARB_CPU;

      if (rd_pend) begin
        if (rd_owner == ARB_CPU) begin
          CPU_RDATA  <= MEM_RDATA;
          CPU_RVALID <= 1'b1;
        end else begin
          REN_RDATA  <= MEM_RDATA;
          REN_RVALID <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Directed bench for screen_mem_arbiter; memory model returns addr ^ 16'hBEFF.
`timescale 1ns/1ps
module tb_screen_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ren_req, ren_we, ren_lock, line_active;
  logic [15:0] cpu_addr, cpu_wdata, ren_addr, ren_wdata;
  logic        cpu_gnt, cpu_rvalid, ren_gnt, ren_rvalid, mem_en, mem_we;
  logic [15:0] cpu_rdata, ren_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  assign mem_rdata = mem_addr ^ 16'hBEFF;

  screen_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(8)) dut (
    .CLK50MHz(clk), .RST(rst),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_GNT(cpu_gnt), .CPU_RDATA(cpu_rdata), .CPU_RVALID(cpu_rvalid),
    .REN_REQ(ren_req), .REN_WE(ren_we), .REN_ADDR(ren_addr), .REN_WDATA(ren_wdata),
    .REN_LOCK(ren_lock), .LINE_ACTIVE(line_active),
    .REN_GNT(ren_gnt), .REN_RDATA(ren_rdata), .REN_RVALID(ren_rvalid),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"},    {30'd0, cpu_gnt, ren_gnt}, 32'd0);
    check_eq({tag, "_rvalid"}, {30'd0, cpu_rvalid, ren_rvalid}, 32'd0);
    check_eq({tag, "_rdata"},  {cpu_rdata, ren_rdata}, 32'd0);
    check_eq({tag, "_mem_ctl"}, {30'd0, mem_en, mem_we}, 32'd0);
    check_eq({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 32'd0);
  endtask

  initial begin
    int cpu_grants;
    int first_idx;
    int ren_after;

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ren_req = 0; ren_we = 0; ren_addr = '0; ren_wdata = '0;
    ren_lock = 0; line_active = 0;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // CPU read 0x0010 -> 0xBEEF
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    step();
    check_eq("cpu_rd_gnt", {29'd0, cpu_gnt, ren_gnt, mem_en}, 32'b101);
    check_eq("cpu_rd_addr", {15'd0, mem_we, mem_addr}, 32'h0010);
    cpu_req = 0;
    step();
    check_eq("cpu_rd_rvalid", {30'd0, cpu_rvalid, ren_rvalid}, 32'b10);
    check_eq("cpu_rd_rdata", cpu_rdata, 32'hBEEF);
    check_eq("cpu_rd_idle", {30'd0, cpu_gnt, mem_en}, 32'd0);
    check_eq("idle_addr_hold", mem_addr, 32'h0010);

    // CPU write: no read return
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    step();
    check_eq("cpu_wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0020, 16'h1234});
    cpu_req = 0; cpu_we = 0;
    step();
    check_eq("cpu_wr_no_rvalid", {30'd0, cpu_rvalid, ren_rvalid}, 32'd0);

    // Renderer-only read 0x0100 -> 0xBFFF
    ren_req = 1; ren_addr = 16'h0100;
    step();
    check_eq("ren_rd_gnt", {30'd0, cpu_gnt, ren_gnt}, 32'b01);
    ren_req = 0;
    step();
    check_eq("ren_rd_rvalid", {30'd0, cpu_rvalid, ren_rvalid}, 32'b01);
    check_eq("ren_rd_rdata", ren_rdata, 32'hBFFF);
    check_eq("cpu_rdata_hold", cpu_rdata, 32'hBEEF);

    // Round-robin with both requesting: CPU, REN, CPU, REN
    cpu_req = 1; cpu_addr = 16'h0A00; ren_req = 1; ren_addr = 16'h0B00;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("rr_gnt%0d", i), {30'd0, cpu_gnt, ren_gnt}, (i % 2 == 0) ? 32'b10 : 32'b01);
      check_eq($sformatf("rr_addr%0d", i), mem_addr, (i % 2 == 0) ? 32'h0A00 : 32'h0B00);
      if (i > 0) begin
        check_eq($sformatf("rr_rvalid%0d", i), {30'd0, cpu_rvalid, ren_rvalid}, (i % 2 == 1) ? 32'b10 : 32'b01);
      end
    end
    cpu_req = 0; ren_req = 0;
    step();
    check_eq("rr_last_ret", {14'd0, cpu_rvalid, ren_rvalid, ren_rdata}, {16'h0001, 16'hB5FF});
    check_eq("rr_cpu_rdata", cpu_rdata, 32'hB4FF);

    // LINE_ACTIVE: renderer wins every tie, CPU served once it drops
    line_active = 1; cpu_req = 1; ren_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("la_gnt%0d", i), {30'd0, cpu_gnt, ren_gnt}, 32'b01);
    end
    line_active = 0;
    step();
    check_eq("la_drop_gnt", {30'd0, cpu_gnt, ren_gnt}, 32'b10);
    cpu_req = 0; ren_req = 0;
    step();

    // Renderer burst lock with a waiting CPU for 20 cycles
    ren_req = 1; ren_lock = 1; ren_addr = 16'h0200;
    step();
    check_eq("lock_first_gnt", {30'd0, cpu_gnt, ren_gnt}, 32'b01);
    cpu_req = 1; cpu_addr = 16'h0C00;
    cpu_grants = 0; first_idx = -1; ren_after = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (first_idx >= 0 && i == first_idx + 1) ren_after = ren_gnt;
      if (cpu_gnt) begin
        cpu_grants++;
        if (first_idx < 0) first_idx = i;
        cpu_req = 0;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    check_eq("guard_cpu_grants", cpu_grants, 32'd1);
    check_eq("guard_first_idx", first_idx, 32'd8);
    check_eq("guard_ren_resume", ren_after, 32'd1);
`else
    check_eq("lock_cpu_grants", cpu_grants, 32'd0);
    check_eq("lock_ren_holds", {30'd0, cpu_gnt, ren_gnt}, 32'b01);
`endif
    cpu_req = 0; ren_req = 0; ren_lock = 0;
    step();
    step();
    check_eq("post_lock_idle", {30'd0, mem_en, mem_we}, 32'd0);

    // Reset during an in-flight CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
    step();
    check_eq("rst_rd_gnt", {30'd0, cpu_gnt, mem_en}, 32'b11);
    cpu_req = 0;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    step();
    check_eq("rst_no_rvalid", {30'd0, cpu_rvalid, ren_rvalid}, 32'd0);
    rst = 1'b0;
    step();

    // Pointer returns to CPU after reset
    cpu_req = 1; ren_req = 1; cpu_addr = 16'h0300; ren_addr = 16'h0400;
    step();
    check_eq("rst_rr_cpu_first", {30'd0, cpu_gnt, ren_gnt}, 32'b10);
    cpu_req = 0; ren_req = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
